// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop process one operand bit per clock.
// Operands enter through an in_valid/in_ready handshake; the registered sum/cout leave through out_valid/out_ready.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic             c;
    logic             c_nxt;
    logic             s;
    logic [CW-1:0]    cnt;
    logic             cout_q;
    logic             accept;
    logic             last_bit;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready is high only in IDLE, out_valid only in DONE; the
    // result stays stable while out_valid is high and out_ready is low.
    assign accept   = (state == IDLE) && in_valid;
    assign last_bit = (state == RUN) && (cnt == LAST);

    always_comb begin
        s      = sa[0] ^ sb[0] ^ c;
        c_nxt  = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
        sr_nxt = sr >> 1;
        sr_nxt[WIDTH-1] = s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)  state_nxt = RUN;
            RUN:  if (last_bit)  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Datapath: operands shift right, the sum bit enters at the MSB so the
    // register holds the full result after WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            c   <= cin;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            c   <= c_nxt;
            sr  <= sr_nxt;
            cnt <= cnt + CW'(1);
            if (last_bit) begin
                cout_q <= c_nxt;
            end
        end
    end

    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sr;
    assign cout      = cout_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=4 main instance plus WIDTH=8 and WIDTH=1 corner instances.
// Expected results are hand-computed constants or an a+b+cin model held in a queue.
module tb_serial_adder;

    logic clk;
    logic rst_n;

    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] sum;
    logic       cout;
    logic       busy;
    logic [1:0] state_dbg;

    logic       v8_in_valid, v8_in_ready, v8_cin, v8_out_valid, v8_out_ready, v8_cout, v8_busy;
    logic [7:0] v8_a, v8_b, v8_sum;
    logic [1:0] v8_state;

    logic       v1_in_valid, v1_in_ready, v1_cin, v1_out_valid, v1_out_ready, v1_cout, v1_busy;
    logic [0:0] v1_a, v1_b, v1_sum;
    logic [1:0] v1_state;

    int n_checks = 0;
    int n_err    = 0;

    logic [4:0] exp_q[$];

    serial_adder #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy), .state_dbg(state_dbg)
    );

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
        .a(v8_a), .b(v8_b), .cin(v8_cin), .out_valid(v8_out_valid), .out_ready(v8_out_ready),
        .sum(v8_sum), .cout(v8_cout), .busy(v8_busy), .state_dbg(v8_state)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
        .a(v1_a), .b(v1_b), .cin(v1_cin), .out_valid(v1_out_valid), .out_ready(v1_out_ready),
        .sum(v1_sum), .cout(v1_cout), .busy(v1_busy), .state_dbg(v1_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one full WIDTH=4 operation with out_ready high, checking latency and result
    task automatic op4(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                       input logic tc, input logic [3:0] es, input logic ec);
        a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_in_ready_low"}, in_ready, 0);
        repeat (3) tick();
        check({tag, "_not_done_early"}, out_valid, 0);
        tick();
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        tick();
        check({tag, "_back_idle"}, in_ready, 1);
    endtask

    initial begin
        logic [4:0] got;
        logic [4:0] want;
        in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 0;
        v8_in_valid = 0; v8_a = 0; v8_b = 0; v8_cin = 0; v8_out_ready = 1;
        v1_in_valid = 0; v1_a = 0; v1_b = 0; v1_cin = 0; v1_out_ready = 1;

        // reset state
        rst_n = 1'b0;
        #12;
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_state", state_dbg, 0);

        // test 1: 1101+1001+0 = 1_0110, busy for exactly 5 cycles
        a = 4'b1101; b = 4'b1001; cin = 0; in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_busy_run%0d", i), busy, 1);
            check($sformatf("t1_no_valid_run%0d", i), out_valid, 0);
            tick();
        end
        check("t1_out_valid", out_valid, 1);
        check("t1_busy_done", busy, 1);
        check("t1_sum", sum, 4'b0110);
        check("t1_cout", cout, 1);
        tick();
        check("t1_busy_end", busy, 0);
        check("t1_in_ready", in_ready, 1);

        // test 2: carry-out, then no leak into the next op
        op4("t2a", 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1);
        op4("t2b", 4'b0101, 4'b0010, 1'b0, 4'b0111, 1'b0);

        // test 3: backpressure in DONE with new operands waiting
        a = 4'd3; b = 4'd4; cin = 1; in_valid = 1; out_ready = 0;
        tick();
        in_valid = 0;
        repeat (4) tick();
        a = 4'd1; b = 4'd1; cin = 0; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_hold_valid%0d", i), out_valid, 1);
            check($sformatf("t3_hold_sum%0d", i), sum, 4'd8);
            check($sformatf("t3_hold_cout%0d", i), cout, 0);
            check($sformatf("t3_hold_in_ready%0d", i), in_ready, 0);
            tick();
        end
        out_ready = 1;
        tick();
        check("t3_idle_after_handshake", state_dbg, 0);
        check("t3_in_ready", in_ready, 1);
        tick();
        in_valid = 0;
        check("t3_new_accepted", state_dbg, 1);
        repeat (3) tick();
        check("t3_not_done_early", out_valid, 0);
        tick();
        check("t3_new_valid", out_valid, 1);
        check("t3_new_sum", sum, 4'd2);
        check("t3_new_cout", cout, 0);
        tick();

        // test 4: async reset between edges in RUN cycle 2
        a = 4'd7; b = 4'd7; cin = 1; in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_rst_busy", busy, 0);
        check("t4_rst_out_valid", out_valid, 0);
        check("t4_rst_sum", sum, 0);
        check("t4_rst_cout", cout, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t4_in_ready", in_ready, 1);
        check("t4_no_partial", out_valid, 0);
        op4("t4_next", 4'b0011, 4'b0001, 1'b0, 4'b0100, 1'b0);

        // test 5: back-to-back with in_valid and out_ready tied high
        in_valid = 1; out_ready = 1;
        for (int n = 0; n < 200; n++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            cin = 1'($urandom_range(0, 1));
            exp_q.push_back(5'(a) + 5'(b) + 5'(cin));
            tick();
            if (n == 199) in_valid = 0;
            if (n < 4) check($sformatf("t5_accepted%0d", n), in_ready, 0);
            repeat (3) tick();
            if (n < 4) check($sformatf("t5_not_done%0d", n), out_valid, 0);
            tick();
            got = {cout, sum};
            want = exp_q.pop_front();
            check($sformatf("t5_valid%0d", n), out_valid, 1);
            check($sformatf("t5_result%0d", n), got, want);
            tick();
            check($sformatf("t5_ready_after6_%0d", n), in_ready, 1);
        end
        check("t5_queue_empty", exp_q.size(), 0);

        // test 6: WIDTH=8 and WIDTH=1 instances
        v8_a = 8'hFF; v8_b = 8'h01; v8_cin = 0; v8_in_valid = 1;
        tick();
        v8_in_valid = 0;
        repeat (7) tick();
        check("w8_not_done_early", v8_out_valid, 0);
        tick();
        check("w8_valid", v8_out_valid, 1);
        check("w8_sum", v8_sum, 8'h00);
        check("w8_cout", v8_cout, 1);
        tick();
        check("w8_idle", v8_in_ready, 1);

        v1_a = 1'b1; v1_b = 1'b1; v1_cin = 1'b1; v1_in_valid = 1;
        tick();
        v1_in_valid = 0;
        check("w1_run", v1_busy, 1);
        check("w1_run_not_valid", v1_out_valid, 0);
        tick();
        check("w1_valid", v1_out_valid, 1);
        check("w1_sum", v1_sum, 1);
        check("w1_cout", v1_cout, 1);
        tick();
        check("w1_idle", v1_in_ready, 1);

        // final report
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
